// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller.
// Holds the memory-sequencer states and the EXE operand-select codes.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // The younger producer (MEM) wins over WB when both write the same register.
    function automatic logic [1:0] fwd_sel(
        input logic       fwd_en,
        input logic [3:0] src,
        input logic [3:0] mem_dest,
        input logic       mem_wb_en,
        input logic [3:0] wb_dest,
        input logic       wb_wb_en
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (fwd_en && mem_wb_en && (mem_dest == src))
            sel = FWD_MEM;
        else if (fwd_en && wb_wb_en && (wb_dest == src))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Combinational forwarding unit: picks the EXE operand source for rn and rm.
module fwd_unit
    import pipeline_pkg::*;
(
    input  logic       fwd_en,
    input  logic [3:0] ex_rn,
    input  logic [3:0] ex_rm,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    input  logic [3:0] wb_dest,
    input  logic       wb_wb_en,
    output logic [1:0] sel_src1,
    output logic [1:0] sel_src2
);

    always_comb begin
        sel_src1 = fwd_sel(fwd_en, ex_rn, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
        sel_src2 = fwd_sel(fwd_en, ex_rm, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, flush and memory-wait sequencing for the 5-stage ARM pipeline.
// Branch flushes seen during a memory stall are held until the stall ends.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [3:0]       ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_r_en,
    input  logic [3:0]       ex_rn,
    input  logic [3:0]       ex_rm,
    input  logic             ex_branch_taken,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic             cnt_clr,
    output logic             freeze_front,
    output logic             bubble_id,
    output logic             flush,
    output logic             stall_all,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t     state;
    logic [TO_W-1:0] to_cnt;
    logic            branch_pending;
    logic            br;
    logic            raw_hz;
    logic            rn_ex, rm_ex, rn_mem, rm_mem;

    always_comb begin
        rn_ex  = id_uses_rn && ex_wb_en  && (id_rn == ex_dest);
        rm_ex  = id_uses_rm && ex_wb_en  && (id_rm == ex_dest);
        rn_mem = id_uses_rn && mem_wb_en && (id_rn == mem_dest);
        rm_mem = id_uses_rm && mem_wb_en && (id_rm == mem_dest);

        // With forwarding only a load result is too late for the next instruction.
        if (fwd_en)
            raw_hz = ex_mem_r_en && (rn_ex || rm_ex);
        else
            raw_hz = rn_ex || rm_ex || rn_mem || rm_mem;

        stall_all = ((state == MEM_WAIT) && !mem_ready)
                  || ((state == RUN) && mem_req && !mem_ready)
                  || (state == ERR);

        br           = ex_branch_taken || branch_pending;
        flush        = br && !stall_all;
        freeze_front = stall_all || (raw_hz && !br);
        bubble_id    = raw_hz && !br && !stall_all;
    end

    fwd_unit u_fwd_unit (
        .fwd_en    (fwd_en),
        .ex_rn     (ex_rn),
        .ex_rm     (ex_rm),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel_src1  (sel_src1),
        .sel_src2  (sel_src2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            to_cnt         <= '0;
            mem_err        <= 1'b0;
            branch_pending <= 1'b0;
            stall_cnt      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state  <= MEM_WAIT;
                        to_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (to_cnt == TO_LAST) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: state <= RUN;
            endcase

            if (flush)
                branch_pending <= 1'b0;
            else if (ex_branch_taken && stall_all)
                branch_pending <= 1'b1;

            if (cnt_clr)
                stall_cnt <= '0;
            else if (freeze_front && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of combinational hazard/forwarding
// vectors plus hand-written memory-wait, deferred-branch and timeout sequences.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en;
    logic [3:0]  id_rn, id_rm;
    logic        id_uses_rn, id_uses_rm;
    logic [3:0]  ex_dest;
    logic        ex_wb_en, ex_mem_r_en;
    logic [3:0]  ex_rn, ex_rm;
    logic        ex_branch_taken;
    logic [3:0]  mem_dest;
    logic        mem_wb_en, mem_req, mem_ready;
    logic [3:0]  wb_dest;
    logic        wb_wb_en;
    logic        cnt_clr;
    logic        freeze_front, bubble_id, flush, stall_all, mem_err;
    logic [1:0]  sel_src1, sel_src2;
    logic [15:0] stall_cnt;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .fwd_en          (fwd_en),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_uses_rn      (id_uses_rn),
        .id_uses_rm      (id_uses_rm),
        .ex_dest         (ex_dest),
        .ex_wb_en        (ex_wb_en),
        .ex_mem_r_en     (ex_mem_r_en),
        .ex_rn           (ex_rn),
        .ex_rm           (ex_rm),
        .ex_branch_taken (ex_branch_taken),
        .mem_dest        (mem_dest),
        .mem_wb_en       (mem_wb_en),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .wb_dest         (wb_dest),
        .wb_wb_en        (wb_wb_en),
        .cnt_clr         (cnt_clr),
        .freeze_front    (freeze_front),
        .bubble_id       (bubble_id),
        .flush           (flush),
        .stall_all       (stall_all),
        .sel_src1        (sel_src1),
        .sel_src2        (sel_src2),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    typedef struct {
        logic       fwd_en;
        logic [3:0] id_rn, id_rm;
        logic       uses_rn, uses_rm;
        logic [3:0] ex_dest;
        logic       ex_wb_en, ex_mem_r_en;
        logic [3:0] ex_rn, ex_rm;
        logic       br;
        logic [3:0] mem_dest;
        logic       mem_wb_en;
        logic [3:0] wb_dest;
        logic       wb_wb_en;
        logic       e_freeze, e_bubble, e_flush;
        logic [1:0] e_sel1, e_sel2;
    } vec_t;

    function automatic vec_t mk(
        input int f, input int rn, input int rm, input int urn, input int urm,
        input int exd, input int exwb, input int exmr, input int exrn, input int exrm,
        input int b, input int md, input int mwb, input int wd, input int wwb,
        input int efz, input int ebub, input int efl, input int es1, input int es2
    );
        vec_t v;
        v.fwd_en = f[0];      v.id_rn = rn[3:0];     v.id_rm = rm[3:0];
        v.uses_rn = urn[0];   v.uses_rm = urm[0];    v.ex_dest = exd[3:0];
        v.ex_wb_en = exwb[0]; v.ex_mem_r_en = exmr[0];
        v.ex_rn = exrn[3:0];  v.ex_rm = exrm[3:0];   v.br = b[0];
        v.mem_dest = md[3:0]; v.mem_wb_en = mwb[0];
        v.wb_dest = wd[3:0];  v.wb_wb_en = wwb[0];
        v.e_freeze = efz[0];  v.e_bubble = ebub[0];  v.e_flush = efl[0];
        v.e_sel1 = es1[1:0];  v.e_sel2 = es2[1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic idle();
        fwd_en = 1'b1; id_rn = '0; id_rm = '0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
        ex_dest = '0; ex_wb_en = 1'b0; ex_mem_r_en = 1'b0; ex_rn = '0; ex_rm = '0;
        ex_branch_taken = 1'b0; mem_dest = '0; mem_wb_en = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; wb_dest = '0; wb_wb_en = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        fwd_en = v.fwd_en; id_rn = v.id_rn; id_rm = v.id_rm;
        id_uses_rn = v.uses_rn; id_uses_rm = v.uses_rm;
        ex_dest = v.ex_dest; ex_wb_en = v.ex_wb_en; ex_mem_r_en = v.ex_mem_r_en;
        ex_rn = v.ex_rn; ex_rm = v.ex_rm; ex_branch_taken = v.br;
        mem_dest = v.mem_dest; mem_wb_en = v.mem_wb_en;
        wb_dest = v.wb_dest; wb_wb_en = v.wb_wb_en;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        vecs[0]  = mk(1, 0,0,0,0, 0,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0,0);
        vecs[1]  = mk(1, 1,0,1,0, 1,1,1, 0,0, 0, 0,0, 0,0, 1,1,0, 0,0);
        vecs[2]  = mk(1, 1,0,1,0, 1,1,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0,0);
        vecs[3]  = mk(0, 1,0,1,0, 1,1,0, 0,0, 0, 0,0, 0,0, 1,1,0, 0,0);
        vecs[4]  = mk(0, 0,3,0,1, 0,0,0, 0,0, 0, 3,1, 0,0, 1,1,0, 0,0);
        vecs[5]  = mk(1, 0,3,0,1, 0,0,0, 0,3, 0, 3,1, 0,0, 0,0,0, 0,1);
        vecs[6]  = mk(0, 0,3,0,0, 0,0,0, 0,0, 0, 3,1, 0,0, 0,0,0, 0,0);
        vecs[7]  = mk(1, 0,0,0,0, 0,0,0, 5,5, 0, 5,1, 5,1, 0,0,0, 1,1);
        vecs[8]  = mk(1, 0,0,0,0, 0,0,0, 7,2, 0, 2,0, 7,1, 0,0,0, 2,0);
        vecs[9]  = mk(0, 0,0,0,0, 0,0,0, 5,5, 0, 5,1, 5,1, 0,0,0, 0,0);
        vecs[10] = mk(1, 1,0,1,0, 1,1,1, 0,0, 1, 0,0, 0,0, 0,0,1, 0,0);
        vecs[11] = mk(1, 0,0,0,0, 0,0,0, 0,0, 1, 0,0, 0,0, 0,0,1, 0,0);
        vecs[12] = mk(1, 0,0,0,0, 0,0,0, 4,0, 0, 4,0, 4,1, 0,0,0, 2,0);
        vecs[13] = mk(1, 0,2,0,0, 2,1,1, 0,0, 0, 0,0, 0,0, 0,0,0, 0,0);
        vecs[14] = mk(0, 6,0,1,0, 6,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0,0);

        idle();
        rst = 1'b0;
        #3;
        chk("rst_stall_all", 32'(stall_all), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_freeze", 32'(freeze_front), 32'd0);
        do_reset();

        // Load-use: one bubble cycle, then the bubble reaches EXE.
        @(posedge clk); #1;
        id_rn = 4'd1; id_uses_rn = 1'b1; ex_dest = 4'd1; ex_wb_en = 1'b1; ex_mem_r_en = 1'b1;
        @(negedge clk);
        chk("lu_freeze", 32'(freeze_front), 32'd1);
        chk("lu_bubble", 32'(bubble_id), 32'd1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("lu_freeze_after", 32'(freeze_front), 32'd0);
        chk("lu_bubble_after", 32'(bubble_id), 32'd0);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_freeze", i), 32'(freeze_front), 32'(vecs[i].e_freeze));
            chk($sformatf("v%0d_bubble", i), 32'(bubble_id), 32'(vecs[i].e_bubble));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
            chk($sformatf("v%0d_sel1", i), 32'(sel_src1), 32'(vecs[i].e_sel1));
            chk($sformatf("v%0d_sel2", i), 32'(sel_src2), 32'(vecs[i].e_sel2));
            chk($sformatf("v%0d_stall", i), 32'(stall_all), 32'd0);
        end

        // cnt_clr clears the accumulated count.
        @(posedge clk); #1;
        idle();
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("cnt_clr", 32'(stall_cnt), 32'd0);

        // Memory wait of 4 cycles with a branch arriving mid-stall.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ex_branch_taken = (k == 1);
            @(negedge clk);
            chk($sformatf("mw%0d_stall", k), 32'(stall_all), 32'd1);
            chk($sformatf("mw%0d_flush", k), 32'(flush), 32'd0);
            @(posedge clk); #1;
        end
        ex_branch_taken = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("mw_ready_stall", 32'(stall_all), 32'd0);
        chk("mw_deferred_flush", 32'(flush), 32'd1);
        chk("mw_ready_freeze", 32'(freeze_front), 32'd0);
        @(posedge clk); #1;
        mem_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("mw_back_in_run", 32'(stall_all), 32'd0);
        chk("mw_pending_cleared", 32'(flush), 32'd0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);

        // Timeout into ERR.
        do_reset();
        @(posedge clk); #1;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            if (i == 64) begin
                chk("to_last_wait_err", 32'(mem_err), 32'd0);
                chk("to_last_wait_stall", 32'(stall_all), 32'd1);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_err_stall", 32'(stall_all), 32'd1);
        chk("to_stall_cnt", 32'(stall_cnt), 32'd65);
        @(posedge clk); #1;
        mem_req = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("err_sticky", 32'(mem_err), 32'd1);
        chk("err_stall_sticky", 32'(stall_all), 32'd1);
        #2;
        idle();
        rst = 1'b0;
        #1;
        chk("err_async_rst_err", 32'(mem_err), 32'd0);
        chk("err_async_rst_stall", 32'(stall_all), 32'd0);
        chk("err_async_rst_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted mid-wait.
        @(posedge clk); #1;
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        mem_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall_all), 32'd0);
        chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("mid_rst_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_run", 32'(stall_all), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage ARM pipeline.
- Produces the freeze/flush controls for IF_Stage_Reg, ID_Stage_Reg, EXE_Stage_Reg and MEM_Stage_Reg, plus forwarding selects for the EXE stage.
- Sequences multi-cycle data-memory accesses through a wait/timeout FSM.
- Defers branch flushes that arrive during a memory stall.

Parameters:
- MEM_TIMEOUT, 64: cycles in MEM_WAIT before a memory error is declared.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fwd_en  in  1  1 = forwarding unit enabled.
- id_rn, id_rm  in  4 each  source registers of the instruction in ID.
- id_uses_rn, id_uses_rm  in  1 each  source valid flags for ID.
- ex_dest  in  4  destination of the instruction in EXE.
- ex_wb_en, ex_mem_r_en  in  1 each  write-back and load flags for EXE.
- ex_rn, ex_rm  in  4 each  EXE source registers.
- ex_branch_taken  in  1  branch resolved taken in EXE.
- mem_dest  in  4  destination of the instruction in MEM.
- mem_wb_en  in  1  write-back flag for MEM.
- mem_req  in  1  MEM stage is issuing a load or store.
- mem_ready  in  1  memory completes the access this cycle.
- wb_dest  in  4  destination of the instruction in WB.
- wb_wb_en  in  1  write-back flag for WB.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- freeze_front  out  1  hold IF_Stage_Reg and the PC.
- bubble_id  out  1  load a NOP (all enables 0) into ID_Stage_Reg.
- flush  out  1  clear IF_Stage_Reg and ID_Stage_Reg.
- stall_all  out  1  freeze every stage register and the PC.
- sel_src1, sel_src2  out  2 each  EXE operand select: 00 register file, 01 MEM ALU result, 10 WB value.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=0, asynchronous): FSM=RUN, branch_pending=0, timeout counter=0, mem_err=0, stall_cnt=0. Comb outputs then evaluate with stall_all=0 and flush=0.
- FSM RUN:
  - mem_req & ~mem_ready -> MEM_WAIT, timeout counter cleared.
  - mem_req & mem_ready -> stay in RUN; single-cycle access, no stall.
- FSM MEM_WAIT:
  - stall_all=1 while mem_ready=0; counter increments each cycle.
  - mem_ready=1 -> stall_all=0 in that same cycle (combinational), next state RUN.
  - Counter reaching MEM_TIMEOUT-1 with mem_ready still 0 -> ERR.
- FSM ERR: stall_all=1 and mem_err=1 permanently; exit only via reset.
- stall_all = (state==MEM_WAIT & ~mem_ready) | (state==RUN & mem_req & ~mem_ready) | state==ERR.
- Data hazard (raw_hz):
  - fwd_en=1: hazard only on load-use, i.e. ex_mem_r_en & ex_wb_en & ID source matches ex_dest.
  - fwd_en=0: hazard on any ID source matching ex_dest (with ex_wb_en) or mem_dest (with mem_wb_en).
  - Each source comparison is gated by its id_uses_* flag.
- Flush:
  - br = ex_branch_taken | branch_pending.
  - flush = br & ~stall_all.
  - branch_pending is set when ex_branch_taken & stall_all, and cleared in the cycle flush=1.
- Priority: stall_all > flush > raw_hz.
  - freeze_front = stall_all | (raw_hz & ~br).
  - bubble_id = raw_hz & ~br & ~stall_all.
- Forwarding:
  - sel_src1=01 if fwd_en & mem_wb_en & mem_dest==ex_rn.
  - Otherwise sel_src1=10 if fwd_en & wb_wb_en & wb_dest==ex_rn.
  - Otherwise 00. MEM match takes priority over WB.
  - sel_src2 is identical using ex_rm. fwd_en=0 forces 00.
- stall_cnt: +1 in every cycle where freeze_front=1, saturating at all-ones. cnt_clr has priority over increment.
- mem_err and ERR are cleared only by rst.

Decomposition:
- pipeline_pkg holds:
  - FSM state encoding: RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2.
  - Forwarding select constants: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- One natural sub-module: fwd_unit, purely combinational, instantiated once and producing both selects.

Test Plan:
- Load r1 in EXE (ex_mem_r_en=1, ex_dest=1), ID uses rn=1, fwd_en=1 -> freeze_front=1 and bubble_id=1 for exactly 1 cycle; stall_cnt=1.
- fwd_en=0, mem_dest=3 with mem_wb_en=1, id_rm=3 -> bubble_id=1. With fwd_en=1 and the same inputs: bubble_id=0 and sel_src2=01 once the instruction reaches EXE with ex_rm=3.
- mem_req=1, mem_ready low for 4 cycles then high -> stall_all high for 4 cycles, low on the ready cycle; FSM back in RUN.
- ex_branch_taken pulses during a stall -> flush=0 while stalled; flush=1 in the first cycle stall_all=0; branch_pending then 0.
- mem_ready held low -> after 64 cycles mem_err=1 and stall_all stays 1; rst low mid-wait -> all outputs return to reset values immediately.
- Branch and load-use hazard in the same cycle -> flush=1, bubble_id=0, freeze_front=0.
